// File: rtl/xor_parity_rx_if.sv
// Interface: xor_parity_rx_if
// Bundles the serial input and the parallel result signals of the
// xor_parity_rx receiver. The master modport is the receiver side; the
// slave modport is the line driver / result consumer side.
// Optional macro XOR_ERRCNT_EN adds the 8-bit errcnt signal.
interface xor_parity_rx_if #(
    parameter int DATA_W = 8
);
    logic              sin;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              perr;
    logic              ferr;
    logic              busy;
`ifdef XOR_ERRCNT_EN
    logic [7:0]        errcnt;

    modport master (
        input  sin,
        output dout, valid, perr, ferr, busy, errcnt
    );

    modport slave (
        output sin,
        input  dout, valid, perr, ferr, busy, errcnt
    );
`else
    modport master (
        input  sin,
        output dout, valid, perr, ferr, busy
    );

    modport slave (
        output sin,
        input  dout, valid, perr, ferr, busy
    );
`endif
endinterface

// File: rtl/xor_parity_rx.sv
// Module: xor_parity_rx
// Serial frame receiver: start bit, DATA_W data bits LSB first, one
// parity bit, one stop bit. A running XOR of the data bits is combined
// with the received parity bit to flag parity errors; a low stop bit
// flags a framing error and parks the receiver in BRK until the line
// returns high, so a held-low line is never mistaken for a start bit.
// Optional macro XOR_ERRCNT_EN adds a saturating 8-bit error counter.
module xor_parity_rx #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    xor_parity_rx_if.master bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DATA = 3'd1,
        PAR  = 3'd2,
        STOP = 3'd3,
        BRK  = 3'd4
    } state_t;

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              acc_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic              par_q;
    logic [DATA_W-1:0] dout_q;
    logic              valid_q;
    logic              perr_q;
    logic              ferr_q;
`ifdef XOR_ERRCNT_EN
    logic [7:0]        errcnt_q;
`endif

    // Next shift value: data arrives LSB first, so each new bit enters at
    // the top and the first bit ends up in bit 0 after DATA_W shifts.
    always_comb begin
        shift_d             = shift_q >> 1;
        shift_d[DATA_W-1]   = bus.sin;
    end

    // Frame state machine; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= 1'b0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef XOR_ERRCNT_EN
            errcnt_q <= 8'd0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!bus.sin) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        acc_q   <= 1'b0;
                        shift_q <= '0;
                    end
                end
                DATA: begin
                    shift_q <= shift_d;
                    acc_q   <= acc_q ^ bus.sin;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= PAR;
                    end
                end
                PAR: begin
                    par_q   <= acc_q ^ bus.sin ^ ODD;
                    state_q <= STOP;
                end
                STOP: begin
                    dout_q  <= shift_q;
                    perr_q  <= par_q;
                    ferr_q  <= ~bus.sin;
                    valid_q <= 1'b1;
`ifdef XOR_ERRCNT_EN
                    if ((par_q || !bus.sin) && (errcnt_q != 8'hFF)) begin
                        errcnt_q <= errcnt_q + 8'd1;
                    end
`endif
                    state_q <= bus.sin ? IDLE : BRK;
                end
                BRK: begin
                    if (bus.sin) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.dout   = dout_q;
    assign bus.valid  = valid_q;
    assign bus.perr   = perr_q;
    assign bus.ferr   = ferr_q;
    assign bus.busy   = (state_q != IDLE);
`ifdef XOR_ERRCNT_EN
    assign bus.errcnt = errcnt_q;
`endif

endmodule

// File: tb/tb_xor_parity_rx.sv
// Testbench: tb_xor_parity_rx
// Drives whole line sequences into an even-parity and an odd-parity
// receiver. Each frame pushes its expected result and the step at which
// valid must appear onto a queue; results are popped when valid is seen.
// Optional macro XOR_ERRCNT_EN enables errcnt checks.
module tb_xor_parity_rx;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         idx;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   total = 0;
    int   bad   = 0;

    bit         lineBits[$];
    exp_t       expQ[$];
    logic [7:0] cntModel = 8'd0;

    xor_parity_rx_if #(.DATA_W(8)) evenBus ();
    xor_parity_rx_if #(.DATA_W(8)) oddBus ();

    xor_parity_rx #(.DATA_W(8), .ODD(1'b0)) dutEven (
        .clk (clk),
        .rst (rst),
        .bus (evenBus)
    );

    xor_parity_rx #(.DATA_W(8), .ODD(1'b1)) dutOdd (
        .clk (clk),
        .rst (rst),
        .bus (oddBus)
    );

    always #5 clk = ~clk;

    // Appends one frame to the line and records what it must produce.
    task automatic pushFrame(input logic [7:0] data, input bit parBit,
                             input bit stopBit, input bit odd);
        exp_t e;
        lineBits.push_back(1'b0);
        for (int b = 0; b < 8; b++) lineBits.push_back(data[b]);
        lineBits.push_back(parBit);
        lineBits.push_back(stopBit);
        e.data = data;
        e.perr = (^data) ^ parBit ^ odd;
        e.ferr = ~stopBit;
        e.idx  = lineBits.size();
        if (!odd && (e.perr || e.ferr) && cntModel != 8'hFF) cntModel = cntModel + 8'd1;
        e.cnt  = cntModel;
        expQ.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        evenBus.sin = 1'b1;
        oddBus.sin  = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (evenBus.valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", evenBus.valid); end
        total++; if (evenBus.dout !== 8'h00) begin bad++; $display("[TB] FAIL reset_dout: got %h want 00", evenBus.dout); end
        total++; if (evenBus.perr !== 1'b0) begin bad++; $display("[TB] FAIL reset_perr: got %b want 0", evenBus.perr); end
        total++; if (evenBus.ferr !== 1'b0) begin bad++; $display("[TB] FAIL reset_ferr: got %b want 0", evenBus.ferr); end
        total++; if (evenBus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", evenBus.busy); end
        total++; if (oddBus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_odd_busy: got %b want 0", oddBus.busy); end
`ifdef XOR_ERRCNT_EN
        total++; if (evenBus.errcnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_errcnt: got %0d want 0", evenBus.errcnt); end
`endif
        rst = 1'b0;
        cntModel = 8'd0;
        repeat (3) @(negedge clk);
        total++; if (evenBus.busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy: got %b want 0", evenBus.busy); end
    endtask

    task automatic test_good_frame();
        exp_t e;
        pushFrame(8'hA5, 1'b0, 1'b1, 1'b0);
        lineBits.push_back(1'b1); lineBits.push_back(1'b1);
        for (int i = 0; i <= lineBits.size(); i++) begin
            @(negedge clk);
            if (evenBus.valid === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin bad++; $display("[TB] FAIL good_spurious: valid at step %0d with no frame pending", i); end
                else begin
                    e = expQ.pop_front();
                    if (i != e.idx) begin bad++; $display("[TB] FAIL good_timing: valid at step %0d want %0d", i, e.idx); end
                    total++; if (evenBus.dout !== e.data) begin bad++; $display("[TB] FAIL good_dout: got %h want %h", evenBus.dout, e.data); end
                    total++; if (evenBus.perr !== e.perr) begin bad++; $display("[TB] FAIL good_perr: got %b want %b", evenBus.perr, e.perr); end
                    total++; if (evenBus.ferr !== e.ferr) begin bad++; $display("[TB] FAIL good_ferr: got %b want %b", evenBus.ferr, e.ferr); end
`ifdef XOR_ERRCNT_EN
                    total++; if (evenBus.errcnt !== e.cnt) begin bad++; $display("[TB] FAIL good_errcnt: got %0d want %0d", evenBus.errcnt, e.cnt); end
`endif
                end
            end
            if (i < lineBits.size()) evenBus.sin = lineBits[i];
        end
        total++; if (expQ.size() != 0) begin bad++; $display("[TB] FAIL good_missing: %0d frames without valid, want 0", expQ.size()); end
        lineBits.delete(); expQ.delete();
    endtask

    task automatic test_parity_error();
        exp_t e;
        pushFrame(8'h07, 1'b0, 1'b1, 1'b0);
        lineBits.push_back(1'b1); lineBits.push_back(1'b1);
        for (int i = 0; i <= lineBits.size(); i++) begin
            @(negedge clk);
            if (evenBus.valid === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin bad++; $display("[TB] FAIL perr_spurious: valid at step %0d with no frame pending", i); end
                else begin
                    e = expQ.pop_front();
                    if (i != e.idx) begin bad++; $display("[TB] FAIL perr_timing: valid at step %0d want %0d", i, e.idx); end
                    total++; if (evenBus.dout !== e.data) begin bad++; $display("[TB] FAIL perr_dout: got %h want %h", evenBus.dout, e.data); end
                    total++; if (evenBus.perr !== e.perr) begin bad++; $display("[TB] FAIL perr_perr: got %b want %b", evenBus.perr, e.perr); end
                    total++; if (evenBus.ferr !== e.ferr) begin bad++; $display("[TB] FAIL perr_ferr: got %b want %b", evenBus.ferr, e.ferr); end
`ifdef XOR_ERRCNT_EN
                    total++; if (evenBus.errcnt !== e.cnt) begin bad++; $display("[TB] FAIL perr_errcnt: got %0d want %0d", evenBus.errcnt, e.cnt); end
`endif
                end
            end
            if (i < lineBits.size()) evenBus.sin = lineBits[i];
        end
        total++; if (expQ.size() != 0) begin bad++; $display("[TB] FAIL perr_missing: %0d frames without valid, want 0", expQ.size()); end
        total++; if (evenBus.perr !== 1'b1) begin bad++; $display("[TB] FAIL perr_hold: got %b want 1", evenBus.perr); end
        lineBits.delete(); expQ.delete();
    endtask

    task automatic test_odd_parity();
        exp_t e;
        pushFrame(8'h00, 1'b1, 1'b1, 1'b1);
        pushFrame(8'h00, 1'b0, 1'b1, 1'b1);
        lineBits.push_back(1'b1); lineBits.push_back(1'b1);
        for (int i = 0; i <= lineBits.size(); i++) begin
            @(negedge clk);
            if (oddBus.valid === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin bad++; $display("[TB] FAIL odd_spurious: valid at step %0d with no frame pending", i); end
                else begin
                    e = expQ.pop_front();
                    if (i != e.idx) begin bad++; $display("[TB] FAIL odd_timing: valid at step %0d want %0d", i, e.idx); end
                    total++; if (oddBus.dout !== e.data) begin bad++; $display("[TB] FAIL odd_dout: got %h want %h", oddBus.dout, e.data); end
                    total++; if (oddBus.perr !== e.perr) begin bad++; $display("[TB] FAIL odd_perr: got %b want %b", oddBus.perr, e.perr); end
                    total++; if (oddBus.ferr !== e.ferr) begin bad++; $display("[TB] FAIL odd_ferr: got %b want %b", oddBus.ferr, e.ferr); end
                end
            end
            if (i < lineBits.size()) oddBus.sin = lineBits[i];
        end
        total++; if (expQ.size() != 0) begin bad++; $display("[TB] FAIL odd_missing: %0d frames without valid, want 0", expQ.size()); end
        lineBits.delete(); expQ.delete();
    endtask

    task automatic test_framing();
        exp_t e;
        pushFrame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (5) lineBits.push_back(1'b0);
        lineBits.push_back(1'b1);
        pushFrame(8'h81, 1'b0, 1'b1, 1'b0);
        lineBits.push_back(1'b1); lineBits.push_back(1'b1);
        for (int i = 0; i <= lineBits.size(); i++) begin
            @(negedge clk);
            if (evenBus.valid === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin bad++; $display("[TB] FAIL frm_spurious: valid at step %0d with no frame pending", i); end
                else begin
                    e = expQ.pop_front();
                    if (i != e.idx) begin bad++; $display("[TB] FAIL frm_timing: valid at step %0d want %0d", i, e.idx); end
                    total++; if (evenBus.dout !== e.data) begin bad++; $display("[TB] FAIL frm_dout: got %h want %h", evenBus.dout, e.data); end
                    total++; if (evenBus.perr !== e.perr) begin bad++; $display("[TB] FAIL frm_perr: got %b want %b", evenBus.perr, e.perr); end
                    total++; if (evenBus.ferr !== e.ferr) begin bad++; $display("[TB] FAIL frm_ferr: got %b want %b", evenBus.ferr, e.ferr); end
`ifdef XOR_ERRCNT_EN
                    total++; if (evenBus.errcnt !== e.cnt) begin bad++; $display("[TB] FAIL frm_errcnt: got %0d want %0d", evenBus.errcnt, e.cnt); end
`endif
                end
            end
            if (i < lineBits.size()) evenBus.sin = lineBits[i];
        end
        total++; if (expQ.size() != 0) begin bad++; $display("[TB] FAIL frm_missing: %0d frames without valid, want 0", expQ.size()); end
        lineBits.delete(); expQ.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        pushFrame(8'h12, 1'b0, 1'b1, 1'b0);
        pushFrame(8'h34, 1'b1, 1'b1, 1'b0);
        lineBits.push_back(1'b1); lineBits.push_back(1'b1);
        for (int i = 0; i <= lineBits.size(); i++) begin
            @(negedge clk);
            if (evenBus.valid === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin bad++; $display("[TB] FAIL b2b_spurious: valid at step %0d with no frame pending", i); end
                else begin
                    e = expQ.pop_front();
                    if (i != e.idx) begin bad++; $display("[TB] FAIL b2b_timing: valid at step %0d want %0d", i, e.idx); end
                    total++; if (evenBus.dout !== e.data) begin bad++; $display("[TB] FAIL b2b_dout: got %h want %h", evenBus.dout, e.data); end
                    total++; if (evenBus.perr !== e.perr) begin bad++; $display("[TB] FAIL b2b_perr: got %b want %b", evenBus.perr, e.perr); end
                    total++; if (evenBus.ferr !== e.ferr) begin bad++; $display("[TB] FAIL b2b_ferr: got %b want %b", evenBus.ferr, e.ferr); end
                end
            end
            if (i < lineBits.size()) evenBus.sin = lineBits[i];
        end
        total++; if (expQ.size() != 0) begin bad++; $display("[TB] FAIL b2b_missing: %0d frames without valid, want 0", expQ.size()); end
        lineBits.delete(); expQ.delete();
    endtask

    task automatic test_midframe_reset();
        exp_t e;
        @(negedge clk); evenBus.sin = 1'b0;
        repeat (4) begin @(negedge clk); evenBus.sin = 1'b1; end
        @(negedge clk);
        total++; if (evenBus.busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy: got %b want 1", evenBus.busy); end
        evenBus.sin = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cntModel = 8'd0;
        total++; if (evenBus.valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid: got %b want 0", evenBus.valid); end
        total++; if (evenBus.dout !== 8'h00) begin bad++; $display("[TB] FAIL mid_dout: got %h want 00", evenBus.dout); end
        total++; if (evenBus.perr !== 1'b0) begin bad++; $display("[TB] FAIL mid_perr: got %b want 0", evenBus.perr); end
        total++; if (evenBus.ferr !== 1'b0) begin bad++; $display("[TB] FAIL mid_ferr: got %b want 0", evenBus.ferr); end
        total++; if (evenBus.busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy_rst: got %b want 0", evenBus.busy); end
`ifdef XOR_ERRCNT_EN
        total++; if (evenBus.errcnt !== 8'd0) begin bad++; $display("[TB] FAIL mid_errcnt: got %0d want 0", evenBus.errcnt); end
`endif
        lineBits.push_back(1'b1);
        pushFrame(8'h55, 1'b0, 1'b1, 1'b0);
        lineBits.push_back(1'b1); lineBits.push_back(1'b1);
        for (int i = 0; i <= lineBits.size(); i++) begin
            @(negedge clk);
            if (evenBus.valid === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin bad++; $display("[TB] FAIL mid_spurious: valid at step %0d with no frame pending", i); end
                else begin
                    e = expQ.pop_front();
                    if (i != e.idx) begin bad++; $display("[TB] FAIL mid_timing: valid at step %0d want %0d", i, e.idx); end
                    total++; if (evenBus.dout !== e.data) begin bad++; $display("[TB] FAIL mid_dout2: got %h want %h", evenBus.dout, e.data); end
                    total++; if (evenBus.perr !== e.perr) begin bad++; $display("[TB] FAIL mid_perr2: got %b want %b", evenBus.perr, e.perr); end
                    total++; if (evenBus.ferr !== e.ferr) begin bad++; $display("[TB] FAIL mid_ferr2: got %b want %b", evenBus.ferr, e.ferr); end
                end
            end
            if (i < lineBits.size()) evenBus.sin = lineBits[i];
        end
        total++; if (expQ.size() != 0) begin bad++; $display("[TB] FAIL mid_missing: %0d frames without valid, want 0", expQ.size()); end
        lineBits.delete(); expQ.delete();
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        evenBus.sin = 1'b1;
        oddBus.sin  = 1'b1;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_odd_parity();
        test_framing();
        test_back_to_back();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Stops a run that somehow never reaches the summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/xor_parity_rx.md
Name: xor_parity_rx

Overview:
- Serial frame receiver with XOR-tree parity check.
- Receiving end of the library's XOR parity-generator/serial-transmit path.
- Takes one line bit per clock, deframes start/data/parity/stop, recomputes running XOR parity, flags parity and framing errors.
- Sits between the serial pin and the parallel register file in the lab datapath.

Parameters:
- DATA_W, 8, data bits per frame, LSB first; legal range 1..16.
- ODD, 0, parity sense: 0 = even (XOR of data and parity bit = 0), 1 = odd (XOR = 1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- sin  in  1  serial line; idle = 1; sampled once per rising clk.
- dout  out  DATA_W  last received data word; holds until the next frame completes.
- valid  out  1  one-cycle pulse when dout, perr and ferr update.
- perr  out  1  parity error of last frame; valid with valid, held after.
- ferr  out  1  stop bit sampled 0 on last frame; valid with valid, held after.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - rst sampled high forces state IDLE, bit counter 0, XOR accumulator 0, shift register 0.
  - Outputs on reset: dout=0, valid=0, perr=0, ferr=0, busy=0.
  - rst overrides mid-frame; the partial frame is discarded with no valid pulse.
- FSM states: IDLE, DATA, PAR, STOP, BRK.
- IDLE:
  - sin=0 (start bit) -> DATA; clear counter, accumulator and shift register.
  - sin=1 -> stay in IDLE.
- DATA:
  - Shift sin into the MSB of the shift register (right shift), so after DATA_W bits the first bit received is in bit 0.
  - acc <= acc ^ sin; counter increments.
  - When counter = DATA_W-1 on this cycle -> PAR.
- PAR:
  - Capture p = acc ^ sin ^ ODD; p=1 means parity error.
  - -> STOP.
- STOP:
  - Register dout <= shift, perr <= p, ferr <= ~sin.
  - Pulse valid on the next cycle.
  - sin=1 -> IDLE.
  - sin=0 -> BRK.
- BRK: wait for sin=1, then -> IDLE. A low line is never taken as a new start bit in BRK.
- Timing:
  - Start bit sampled at edge N; data at N+1..N+DATA_W; parity at N+DATA_W+1; stop at N+DATA_W+2.
  - valid=1, with new dout/perr/ferr, during the cycle after edge N+DATA_W+2.
  - With DATA_W=8, valid is high 11 cycles after start-bit sampling.
- Back-to-back frames: a start bit sampled on the edge immediately after STOP (sin=1 at stop) is accepted from IDLE; there is no minimum idle gap.
- valid and the IDLE->DATA transition may occur in the same cycle.
- perr and ferr are independent; both may be set for one frame.
- Glitches: sin is assumed synchronous to clk; no metastability filtering in this block.

Optional Feature:
- XOR_ERRCNT_EN defined:
  - Adds output errcnt, 8 bits.
  - errcnt increments by 1 on each valid pulse where perr|ferr is set.
  - Saturates at 255; cleared only by rst.
- Not defined: errcnt port absent; no counter logic.

Test Plan:
- Even parity, data 0xA5 (four ones), parity bit 0, stop 1 -> valid after 11 cycles; dout=0xA5, perr=0, ferr=0.
- Even parity, data 0x07, parity bit 0 (wrong) -> dout=0x07, perr=1, ferr=0; with XOR_ERRCNT_EN, errcnt 0->1.
- ODD=1, data 0x00, parity bit 1 -> perr=0; same frame with parity bit 0 -> perr=1.
- Frame 0x3C with stop bit 0, line held low 5 cycles, then high, then a valid frame 0x81 -> first frame ferr=1; no spurious frame during the low period; second frame dout=0x81, ferr=0.
- Two frames 0x12 then 0x34, back-to-back with no idle gap -> two valid pulses 11 cycles apart, dout 0x12 then 0x34.
- rst asserted at data bit 4 of frame 0xFF -> no valid pulse; all outputs 0 next cycle; a following frame 0x55 is received correctly.
